// File: rtl/pzcorebus_response_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_response_burst_arbiter
// Description : Grant controller for one master-side port of the response
//               crossbar. Weighted round-robin over SOURCES response sources,
//               one burst per grant; a multi-beat burst is never interleaved.
//               Produces the per-port select only, no datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_response_burst_arbiter #(
    parameter int SOURCES      = 2,
    parameter int WEIGHT_WIDTH = 2,
    parameter int INDEX_WIDTH  = $clog2(SOURCES)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [SOURCES-1:0]              i_valid,
    input  logic [SOURCES-1:0]              i_last,
    input  logic [SOURCES*WEIGHT_WIDTH-1:0] i_weight,
    input  logic                            i_ready,
    output logic [SOURCES-1:0]              o_grant,
    output logic [INDEX_WIDTH-1:0]          o_grant_index,
    output logic [SOURCES-1:0]              o_ready,
    output logic                            o_locked
);

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH-1:0]  C_LAST_INDEX = INDEX_WIDTH'(SOURCES - 1);
    localparam logic [WEIGHT_WIDTH-1:0] C_ONE_CREDIT = WEIGHT_WIDTH'(1);

    // Registered state
    state_t                  r_state_q;
    logic [INDEX_WIDTH-1:0]  r_lock_index_q;
    logic [INDEX_WIDTH-1:0]  r_rr_pointer_q;
    logic [WEIGHT_WIDTH-1:0] r_credit_q;
    // Credit is loaded lazily: right after reset the weight of source 0 is
    // taken straight from the input until the first clock captures it.
    logic                    r_credit_loaded_q;

    // Next-state values
    state_t                  w_state_d;
    logic [INDEX_WIDTH-1:0]  w_lock_index_d;
    logic [INDEX_WIDTH-1:0]  w_rr_pointer_d;
    logic [WEIGHT_WIDTH-1:0] w_credit_d;
    logic                    w_credit_loaded_d;

    // Combinational helpers
    logic [WEIGHT_WIDTH-1:0] w_weight_eff [SOURCES];
    logic [WEIGHT_WIDTH-1:0] w_credit_cur;
    logic                    w_free_found;
    logic [INDEX_WIDTH-1:0]  w_free_index;
    logic                    w_grant_valid;
    logic [INDEX_WIDTH-1:0]  w_grant_index;
    logic                    w_accept;
    logic                    w_burst_done;
    logic [INDEX_WIDTH-1:0]  w_done_next;
    logic [INDEX_WIDTH-1:0]  w_ptr_next;

    function automatic logic [INDEX_WIDTH-1:0] next_index(input logic [INDEX_WIDTH-1:0] idx);
        if (idx == C_LAST_INDEX) begin
            return '0;
        end
        return idx + INDEX_WIDTH'(1);
    endfunction

    // Unpack per-source weights, a zero weight behaves as one
    always_comb begin
        for (int s = 0; s < SOURCES; s++) begin
            w_weight_eff[s] = (i_weight[s*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                            ? C_ONE_CREDIT
                            : i_weight[s*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    // Round-robin search: first valid source at or after the pointer, with wrap
    always_comb begin
        w_free_found = 1'b0;
        w_free_index = '0;
        for (int k = SOURCES - 1; k >= 0; k--) begin
            int cand;
            cand = int'(r_rr_pointer_q) + k;
            if (cand >= SOURCES) begin
                cand = cand - SOURCES;
            end
            if (i_valid[INDEX_WIDTH'(cand)]) begin
                w_free_found = 1'b1;
                w_free_index = INDEX_WIDTH'(cand);
            end
        end
    end

    // Grant selection, burst tracking and credit / pointer bookkeeping
    always_comb begin
        w_state_d         = r_state_q;
        w_lock_index_d    = r_lock_index_q;
        w_rr_pointer_d    = r_rr_pointer_q;
        w_credit_cur      = r_credit_loaded_q ? r_credit_q : w_weight_eff[r_rr_pointer_q];
        w_credit_d        = w_credit_cur;
        w_credit_loaded_d = 1'b1;
        w_grant_valid     = 1'b0;
        w_grant_index     = '0;
        w_accept          = 1'b0;
        w_burst_done      = 1'b0;
        w_done_next       = '0;
        w_ptr_next        = next_index(r_rr_pointer_q);

        if (i_rst_n) begin
            case (r_state_q)
                ST_FREE: begin
                    w_grant_valid = w_free_found;
                    w_grant_index = w_free_index;
                    w_accept      = w_free_found & i_ready;
                    if (w_accept && !i_last[w_free_index]) begin
                        w_state_d      = ST_LOCKED;
                        w_lock_index_d = w_free_index;
                    end
                end
                ST_LOCKED: begin
                    // A bubble on the owning source keeps the lock
                    w_grant_valid = 1'b1;
                    w_grant_index = r_lock_index_q;
                    w_accept      = i_valid[r_lock_index_q] & i_ready;
                    if (w_accept && i_last[r_lock_index_q]) begin
                        w_state_d = ST_FREE;
                    end
                end
                default: begin
                    w_state_d = ST_FREE;
                end
            endcase
        end

        w_burst_done = w_accept & i_last[w_grant_index];
        w_done_next  = next_index(w_grant_index);

        if (w_burst_done) begin
            if ((w_grant_index == r_rr_pointer_q) && (w_credit_cur > C_ONE_CREDIT)) begin
                w_credit_d = w_credit_cur - C_ONE_CREDIT;
            end else begin
                w_rr_pointer_d = w_done_next;
                w_credit_d     = w_weight_eff[w_done_next];
            end
        end else if ((r_state_q == ST_FREE) && (|i_valid) && !i_valid[r_rr_pointer_q]) begin
            // Pointer source is idle while others wait: its unused credit is lost
            w_rr_pointer_d = w_ptr_next;
            w_credit_d     = w_weight_eff[w_ptr_next];
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q         <= ST_FREE;
            r_lock_index_q    <= '0;
            r_rr_pointer_q    <= '0;
            r_credit_q        <= '0;
            r_credit_loaded_q <= 1'b0;
        end else begin
            r_state_q         <= w_state_d;
            r_lock_index_q    <= w_lock_index_d;
            r_rr_pointer_q    <= w_rr_pointer_d;
            r_credit_q        <= w_credit_d;
            r_credit_loaded_q <= w_credit_loaded_d;
        end
    end

    // Output decode: one-hot grant, ready routed only to the granted source
    always_comb begin
        o_grant = '0;
        if (w_grant_valid) begin
            o_grant[w_grant_index] = 1'b1;
        end
        o_grant_index = w_grant_valid ? w_grant_index : '0;
        o_ready       = o_grant & {SOURCES{i_ready}};
        o_locked      = i_rst_n && (r_state_q == ST_LOCKED);
    end

`ifndef SYNTHESIS
    a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
    a_grant_stable_locked : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_locked ##1 o_locked) |-> $stable(o_grant));
    a_free_grant_valid : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (!o_locked && (o_grant != '0)) |-> i_valid[o_grant_index]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pzcorebus_response_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pzcorebus_response_burst_arbiter
// Description : Randomized scoreboard bench for the response burst arbiter,
//               four sources, two-bit weights.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pzcorebus_response_burst_arbiter;

    localparam int N  = 4;
    localparam int WW = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [N*WW-1:0] weight;
    logic          ready;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic [N-1:0]  ordy;
    logic          locked;

    pzcorebus_response_burst_arbiter #(
        .SOURCES      (N),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid),
        .i_last        (last),
        .i_weight      (weight),
        .i_ready       (ready),
        .o_grant       (grant),
        .o_grant_index (gidx),
        .o_ready       (ordy),
        .o_locked      (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [IW-1:0] idx;
        logic [N-1:0]  rdy;
        logic          locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: owner = -1 when no burst is in progress
    int m_ptr, m_credit, m_owner;
    int last_g;
    bit last_acc;

    // Stimulus generator state
    int          rem[N];
    int          p_valid, p_ready, max_len;
    logic [N-1:0] vmask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int eff_w(input int s);
        int w;
        w = int'((weight >> (WW * s)) & 8'h3);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_owner  = -1;
        m_credit = -1;
        last_acc = 1'b0;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model
    task automatic eval();
        exp_t e;
        int   g;
        bit   acc;
        bit   was_free;
        e = '0;
        if (!rst_n) begin
            exp_q.push_back(e);
            model_reset();
            return;
        end
        if (m_credit < 0) m_credit = eff_w(m_ptr);
        g = -1;
        if (m_owner >= 0) begin
            g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (valid[2'(s)]) begin
                    g = s;
                    break;
                end
            end
        end
        if (g >= 0) begin
            e.grant = 4'(1 << g);
            e.idx   = 2'(g);
        end
        e.rdy    = ready ? e.grant : '0;
        e.locked = (m_owner >= 0);
        exp_q.push_back(e);

        acc      = (g >= 0) && valid[2'(g)] && ready;
        was_free = (m_owner < 0);
        if (acc && last[2'(g)]) begin
            m_owner = -1;
            if (g == m_ptr && m_credit > 1) begin
                m_credit--;
            end else begin
                m_ptr    = (g + 1) % N;
                m_credit = eff_w(m_ptr);
            end
        end else begin
            if (acc) m_owner = g;
            if (was_free && valid != '0 && !valid[2'(m_ptr)]) begin
                m_ptr    = (m_ptr + 1) % N;
                m_credit = eff_w(m_ptr);
            end
        end
        last_g   = g;
        last_acc = acc;
    endtask

    task automatic gen_inputs();
        for (int s = 0; s < N; s++) begin
            valid[2'(s)] = vmask[2'(s)] && (int'($urandom_range(99)) < p_valid);
            last[2'(s)]  = (rem[s] == 1);
        end
        ready = (int'($urandom_range(99)) < p_ready);
    endtask

    task automatic post_gen();
        if (last_acc) begin
            if (rem[last_g] <= 1) rem[last_g] = int'($urandom_range(1, max_len));
            else                  rem[last_g]--;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        gen_inputs();
        eval();
        post_gen();
    endtask

    task automatic cycle_release();
        @(negedge clk);
        rst_n = 1'b1;
        gen_inputs();
        eval();
        post_gen();
    endtask

    // Monitor: pops one expectation per driven cycle, sampled mid-low-phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("o_grant",       32'(grant),  32'(e.grant));
                check("o_grant_index", 32'(gidx),   32'(e.idx));
                check("o_ready",       32'(ordy),   32'(e.rdy));
                check("o_locked",      32'(locked), 32'(e.locked));
            end
        end
    end

    initial begin
        bit got_lock;
        rst_n  = 1'b1;
        valid  = '0;
        last   = '0;
        ready  = 1'b0;
        weight = 8'h55;
        vmask  = '1;
        p_valid = 0; p_ready = 0; max_len = 1;
        for (int s = 0; s < N; s++) rem[s] = 1;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) cycle();

        // All sources valid, single beats, unit weights: plain rotation
        p_valid = 100; p_ready = 100; max_len = 1;
        cycle_release();
        repeat (8) cycle();

        // Weighted: src0=3 src1=1 src2=0(->1) src3=2, only src0/src1 requesting
        weight = 8'h87;
        vmask  = 4'b0011;
        repeat (16) cycle();

        // Random multi-beat bursts with backpressure
        vmask = '1; p_valid = 70; p_ready = 70; max_len = 4;
        weight = 8'($urandom());
        repeat (200) cycle();
        weight = 8'($urandom());
        repeat (200) cycle();

        // Bubble-heavy traffic
        p_valid = 40; p_ready = 80;
        repeat (150) cycle();

        // Asynchronous reset in the middle of a locked burst
        p_valid = 80; p_ready = 50; max_len = 4;
        got_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (m_owner >= 0) begin
                got_lock = 1'b1;
                break;
            end
        end
        check("lock_reached", 32'(got_lock), 32'd1);
        cycle();
        #3 rst_n = 1'b0;
        #1;
        check("rst_grant",  32'(grant),  32'd0);
        check("rst_index",  32'(gidx),   32'd0);
        check("rst_ready",  32'(ordy),   32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        model_reset();
        repeat (2) cycle();

        // Restart from source 0 with src3 and src0 requesting
        vmask = 4'b1001; p_valid = 100; p_ready = 100; max_len = 1;
        for (int s = 0; s < N; s++) rem[s] = 1;
        cycle_release();
        repeat (3) cycle();
        vmask = '1; p_valid = 70; p_ready = 70; max_len = 3;
        repeat (100) cycle();

        @(negedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
